// File: rtl/sample_queue.sv
// ============================================================================
//  Module      : sample_queue
//  Description : Sample FIFO feeding a pulse modulator; each sample is held
//                for hold_count+1 pulse_done strobes, gated by a fill threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_queue #(
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 8,
  parameter int DIV_BITS  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       wr_en,
  input  logic                       pulse_done,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [DIV_BITS-1:0]        hold_count,
  input  logic [$clog2(DEPTH):0]     start_level,
  input  logic                       clear_flags,
  output logic [DATA_BITS-1:0]       u_sample,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 state,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]     C_FULL    = LVL_W'(DEPTH);
  localparam logic [DATA_BITS-1:0] C_MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_BITS-1:0]    div_q, div_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;
  logic                   ovf_q, ovf_d;
  logic                   unr_q, unr_d;

  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic pop_try, do_pop, do_push, ovf_evt, unr_evt;

  // A pop attempt on an empty FIFO is an underrun even if a push lands the same cycle.
  always_comb begin
    pop_try = (state_q == ST_RUN) && enable && !flush && pulse_done && (div_q == '0);
    do_pop  = pop_try && (level_q != '0);
    unr_evt = pop_try && (level_q == '0);
    do_push = !flush && wr_en && ((level_q != C_FULL) || do_pop);
    ovf_evt = !flush && wr_en && (level_q == C_FULL) && !do_pop;
  end

  always_comb begin
    level_d  = level_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    sample_d = sample_q;
    if (flush) begin
      level_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop) begin
        rptr_d   = rptr_q + 1'b1;
        sample_d = mem[rptr_q];
      end
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    if (flush) begin
      state_d = enable ? ST_FILL : ST_IDLE;
      div_d   = '0;
    end else if (!enable) begin
      state_d = ST_IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: begin
          if (level_q >= start_level) begin
            state_d = ST_RUN;
            div_d   = '0;
          end
        end
        ST_RUN: begin
          if (pulse_done) begin
            if (div_q != '0)    div_d = div_q - 1'b1;
            else if (do_pop)    div_d = hold_count;
            else                state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    unr_d = unr_q;
    if (clear_flags) begin
      ovf_d = 1'b0;
      unr_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (unr_evt) unr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      level_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      sample_q <= C_MIDSCALE;
      ovf_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      level_q  <= level_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      sample_q <= sample_d;
      ovf_q    <= ovf_d;
      unr_q    <= unr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr_q] <= wr_data;
  end

  assign u_sample = sample_q;
  assign level    = level_q;
  assign state    = state_q;
  assign overflow = ovf_q;
  assign underrun = unr_q;

endmodule

`default_nettype wire
